// File: rtl/vga_text_console.sv
// Byte-stream console front end: cursor tracking, CR/LF/BS/FF handling, Wishbone writes into text RAM.
// Define VGA_CONSOLE_CLEAR_ON_RESET_EN to clear the whole screen after every reset release.
module vga_text_console #(
    parameter int          TEXT_COLS = 40,
    parameter int          TEXT_ROWS = 30,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic        CLK_I,
    input  logic        I_reset_n,
    input  logic [7:0]  I_data,
    input  logic        I_valid,
    output logic        O_ready,
    output logic [12:0] ADR_O,
    output logic [7:0]  DAT_O,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I,
    output logic [5:0]  O_cursor_col,
    output logic [4:0]  O_cursor_row,
    output logic        O_busy
);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WR, S_ACK, S_GAP} state_t;

    localparam logic [5:0]  LAST_COL  = 6'(TEXT_COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(TEXT_ROWS - 1);
    localparam logic [10:0] LAST_CELL = 11'(TEXT_COLS * TEXT_ROWS - 1);

`ifdef VGA_CONSOLE_CLEAR_ON_RESET_EN
    localparam logic CLEAR_ON_RESET = 1'b1;
`else
    localparam logic CLEAR_ON_RESET = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [5:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [10:0] adr_q, adr_d;
    logic [10:0] last_q, last_d;
    logic [7:0]  dat_q, dat_d;
    logic [7:0]  byte_q, byte_d;
    logic        char_op_q, char_op_d;
    logic        more_q, more_d;
    logic        init_q, init_d;

    logic [4:0]  next_row;
    logic [10:0] cur_base;
    logic [10:0] next_base;

    function automatic logic [10:0] row_base(input logic [4:0] r);
        return 11'(r) * 11'(TEXT_COLS);
    endfunction

    assign next_row  = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
    assign cur_base  = row_base(row_q);
    assign next_base = row_base(next_row);

    always_ff @(posedge CLK_I) begin
        if (!I_reset_n) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            adr_q     <= '0;
            last_q    <= '0;
            dat_q     <= '0;
            byte_q    <= '0;
            char_op_q <= 1'b0;
            more_q    <= 1'b0;
            init_q    <= CLEAR_ON_RESET;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            adr_q     <= adr_d;
            last_q    <= last_d;
            dat_q     <= dat_d;
            byte_q    <= byte_d;
            char_op_q <= char_op_d;
            more_q    <= more_d;
            init_q    <= init_d;
        end
    end

    // Every bus operation is a run of writes from adr_q up to last_q with constant data.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        adr_d     = adr_q;
        last_d    = last_q;
        dat_d     = dat_q;
        byte_d    = byte_q;
        char_op_d = char_op_q;
        more_d    = more_q;
        init_d    = init_q;
        O_ready   = 1'b0;

        case (state_q)
            S_IDLE: begin
                O_ready = !init_q;
                if (init_q) begin
                    init_d    = 1'b0;
                    adr_d     = '0;
                    last_d    = LAST_CELL;
                    dat_d     = FILL_CHAR;
                    char_op_d = 1'b0;
                    state_d   = S_WR;
                end else if (I_valid) begin
                    byte_d  = I_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                char_op_d = 1'b0;
                dat_d     = FILL_CHAR;
                state_d   = S_IDLE;
                if (byte_q >= 8'h20) begin
                    adr_d     = cur_base + 11'(col_q);
                    last_d    = cur_base + 11'(col_q);
                    dat_d     = byte_q;
                    char_op_d = 1'b1;
                    state_d   = S_WR;
                end else begin
                    case (byte_q)
                        8'h0D: col_d = '0;
                        8'h0A: begin
                            col_d   = '0;
                            row_d   = next_row;
                            adr_d   = next_base;
                            last_d  = next_base + 11'(LAST_COL);
                            state_d = S_WR;
                        end
                        8'h08: begin
                            if (col_q != 6'd0) begin
                                col_d   = col_q - 6'd1;
                                adr_d   = cur_base + 11'(col_q - 6'd1);
                                last_d  = cur_base + 11'(col_q - 6'd1);
                                state_d = S_WR;
                            end
                        end
                        8'h0C: begin
                            col_d   = '0;
                            row_d   = '0;
                            adr_d   = '0;
                            last_d  = LAST_CELL;
                            state_d = S_WR;
                        end
                        default: ;
                    endcase
                end
            end
            S_WR: state_d = S_ACK;
            S_ACK: begin
                if (ACK_I) begin
                    state_d = S_GAP;
                    more_d  = 1'b0;
                    if (adr_q != last_q) begin
                        adr_d  = adr_q + 11'd1;
                        more_d = 1'b1;
                    end else if (char_op_q) begin
                        // Printable write done: advance cursor, wrapping into a row clear at the last column.
                        char_op_d = 1'b0;
                        if (col_q == LAST_COL) begin
                            col_d  = '0;
                            row_d  = next_row;
                            adr_d  = next_base;
                            last_d = next_base + 11'(LAST_COL);
                            dat_d  = FILL_CHAR;
                            more_d = 1'b1;
                        end else begin
                            col_d = col_q + 6'd1;
                        end
                    end
                end
            end
            S_GAP: state_d = more_q ? S_WR : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign STB_O        = (state_q == S_WR) || (state_q == S_ACK);
    assign WE_O         = STB_O;
    assign ADR_O        = {2'b00, adr_q};
    assign DAT_O        = dat_q;
    assign O_cursor_col = col_q;
    assign O_cursor_row = row_q;
    assign O_busy       = (state_q != S_IDLE) || init_q;

endmodule

// File: tb/tb_vga_text_console.sv
// Self-checking bench for vga_text_console: table-driven byte vectors plus directed wrap/reset sequences.
module tb_vga_text_console;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  data_in = '0;
    logic        valid_in = 1'b0;
    logic        ready;
    logic [12:0] adr;
    logic [7:0]  dat;
    logic        stb;
    logic        we;
    logic        ack = 1'b0;
    logic [5:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int ack_delay = 1;
    int ack_cnt = 0;
    int we_errs = 0;
    int gap_errs = 0;
    int hold_errs = 0;
    int adr_log[$];
    int dat_log[$];
    logic        prev_stb = 1'b0;
    logic        prev_ack = 1'b0;
    logic [12:0] prev_adr = '0;
    logic [7:0]  prev_dat = '0;

    typedef struct {
        logic [7:0] data;
        int         col;
        int         row;
        int         n;
        int         first;
        int         last;
        int         wdat;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    vga_text_console dut (
        .CLK_I        (clk),
        .I_reset_n    (reset_n),
        .I_data       (data_in),
        .I_valid      (valid_in),
        .O_ready      (ready),
        .ADR_O        (adr),
        .DAT_O        (dat),
        .STB_O        (stb),
        .WE_O         (we),
        .ACK_I        (ack),
        .O_cursor_col (cur_col),
        .O_cursor_row (cur_row),
        .O_busy       (busy)
    );

    // Slave model: acks ack_delay cycles after strobe rises, then drops ack for one cycle.
    always @(posedge clk) begin
        if (!stb || ack) begin
            ack_cnt <= 0;
            ack     <= 1'b0;
        end else begin
            if (ack_cnt == ack_delay - 1) ack <= 1'b1;
            ack_cnt <= ack_cnt + 1;
        end
    end

    // Bus monitor: logs completed writes and tracks protocol rule breaks.
    always @(negedge clk) begin
        if (we !== stb) we_errs++;
        if (reset_n) begin
            if (prev_stb && prev_ack && stb) gap_errs++;
            if (prev_stb && !prev_ack && (!stb || adr !== prev_adr || dat !== prev_dat)) hold_errs++;
            if (stb && ack) begin
                adr_log.push_back(int'(adr));
                dat_log.push_back(int'(dat));
            end
        end
        prev_stb = stb && reset_n;
        prev_ack = ack;
        prev_adr = adr;
        prev_dat = dat;
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_log();
        adr_log.delete();
        dat_log.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) check_output("idle timeout", 1, 0);
    endtask

    task automatic apply_stimulus(input logic [7:0] b);
        wait_idle(20000);
        #1;
        data_in  = b;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        wait_idle(20000);
    endtask

    task automatic check_writes(input string name, input int n, input int first, input int last, input int wdat);
        int bad = 0;
        check_output({name, " count"}, adr_log.size(), n);
        if (n > 0 && adr_log.size() > 0) begin
            check_output({name, " first adr"}, adr_log[0], first);
            check_output({name, " last adr"}, adr_log[adr_log.size()-1], last);
            foreach (adr_log[i]) begin
                if (dat_log[i] != wdat) bad++;
                if (i > 0 && adr_log[i] != adr_log[i-1] + 1) bad++;
            end
            check_output({name, " sequence"}, bad, 0);
        end
    endtask

    task automatic check_cursor(input string name, input int col, input int row);
        check_output({name, " col"}, int'(cur_col), col);
        check_output({name, " row"}, int'(cur_row), row);
    endtask

    task automatic do_reset(input logic check_values);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (check_values) begin
            check_output("reset stb", int'(stb), 0);
            check_output("reset we", int'(we), 0);
            check_output("reset adr", int'(adr), 0);
            check_output("reset dat", int'(dat), 0);
            check_cursor("reset", 0, 0);
        end
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        if (check_values) begin
`ifdef VGA_CONSOLE_CLEAR_ON_RESET_EN
            check_output("post-reset ready", int'(ready), 0);
            check_output("post-reset busy", int'(busy), 1);
`else
            check_output("post-reset ready", int'(ready), 1);
            check_output("post-reset busy", int'(busy), 0);
`endif
        end
        wait_idle(20000);
        clear_log();
    endtask

    initial begin
        int n;
        vecs[0]  = '{8'h41, 1, 0, 1,  0,  0, 8'h41};
        vecs[1]  = '{8'h42, 2, 0, 1,  1,  1, 8'h42};
        vecs[2]  = '{8'h0D, 0, 0, 0,  0,  0, 0};
        vecs[3]  = '{8'h01, 0, 0, 0,  0,  0, 0};
        vecs[4]  = '{8'h08, 0, 0, 0,  0,  0, 0};
        vecs[5]  = '{8'h7E, 1, 0, 1,  0,  0, 8'h7E};
        vecs[6]  = '{8'h0A, 0, 1, 40, 40, 79, 8'h20};
        vecs[7]  = '{8'h43, 1, 1, 1,  40, 40, 8'h43};
        vecs[8]  = '{8'h44, 2, 1, 1,  41, 41, 8'h44};
        vecs[9]  = '{8'h08, 1, 1, 1,  41, 41, 8'h20};
        vecs[10] = '{8'h20, 2, 1, 1,  41, 41, 8'h20};
        vecs[11] = '{8'h0D, 0, 1, 0,  0,  0, 0};

        do_reset(1'b1);

        foreach (vecs[i]) begin
            clear_log();
            apply_stimulus(vecs[i].data);
            check_cursor($sformatf("vec%0d", i), vecs[i].col, vecs[i].row);
            check_writes($sformatf("vec%0d", i), vecs[i].n, vecs[i].first, vecs[i].last, vecs[i].wdat);
        end

        // Printable at the last column wraps the cursor and clears the new row.
        do_reset(1'b0);
        apply_stimulus(8'h0A);
        apply_stimulus(8'h0A);
        for (int i = 0; i < 39; i++) apply_stimulus(8'h78);
        check_cursor("at 39,2", 39, 2);
        clear_log();
        apply_stimulus(8'h42);
        check_cursor("wrap", 0, 3);
        check_output("wrap count", adr_log.size(), 41);
        if (adr_log.size() == 41) begin
            check_output("wrap char adr", adr_log[0], 119);
            check_output("wrap char dat", dat_log[0], 8'h42);
            void'(adr_log.pop_front());
            void'(dat_log.pop_front());
            check_writes("wrap clear", 40, 120, 159, 8'h20);
        end

        // LF on the last row wraps to row 0 and clears it.
        do_reset(1'b0);
        for (int i = 0; i < 29; i++) apply_stimulus(8'h0A);
        for (int i = 0; i < 5; i++) apply_stimulus(8'h61);
        check_cursor("at 5,29", 5, 29);
        clear_log();
        apply_stimulus(8'h0A);
        check_cursor("lf wrap", 0, 0);
        check_writes("lf wrap", 40, 0, 39, 8'h20);

        // Backspace mid-row and at column 0.
        do_reset(1'b0);
        apply_stimulus(8'h0A);
        for (int i = 0; i < 3; i++) apply_stimulus(8'h62);
        clear_log();
        apply_stimulus(8'h08);
        check_cursor("bs", 2, 1);
        check_writes("bs", 1, 42, 42, 8'h20);
        apply_stimulus(8'h0D);
        clear_log();
        apply_stimulus(8'h08);
        check_cursor("bs col0", 0, 1);
        check_writes("bs col0", 0, 0, 0, 0);

        // Form feed with a slow slave.
        ack_delay = 4;
        clear_log();
        apply_stimulus(8'h0C);
        check_cursor("ff", 0, 0);
        check_writes("ff", 1200, 0, 1199, 8'h20);
        ack_delay = 1;

        // Reset in the middle of an LF row clear.
        wait_idle(20000);
        #1;
        data_in  = 8'h0A;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(stb && adr == 13'd50) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_output("reach cell 10", int'(stb && adr == 13'd50), 1);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        check_output("mid reset stb", int'(stb), 0);
        check_cursor("mid reset", 0, 0);
`ifdef VGA_CONSOLE_CLEAR_ON_RESET_EN
        check_output("mid reset ready", int'(ready), 0);
`else
        check_output("mid reset ready", int'(ready), 1);
`endif
        #1;
        reset_n = 1'b1;
        wait_idle(20000);

        check_output("we equals stb", we_errs, 0);
        check_output("gap after ack", gap_errs, 0);
        check_output("strobe hold", hold_errs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
